// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the decode-stage output payload.
package riscv_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] CLS_BASE = 2'b00;
  localparam logic [1:0] CLS_ALT  = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_PASS = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [5:0]        alu_control;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              branch_op;
    logic              jump;
    logic [DATA_W-1:0] target;
    logic [4:0]        rd;
    logic              regwrite;
    logic              illegal;
  } decode_out_t;

  function automatic logic [5:0] alu_ctrl(input logic [1:0] cls, input logic [2:0] f3);
    return {1'b0, cls, f3};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction; every immediate is sign-extended to 32 bits.
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a one-entry valid/ready output register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic            branch_op,
  output logic            jump,
  output logic [XLEN-1:0] target,
  output logic [4:0]      rd,
  output logic            regwrite,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        accept;
  decode_out_t dec;
  decode_out_t out_q;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // Opcode decode; an illegal result clears all control fields but still flows on.
  always_comb begin
    dec          = '0;
    dec.rd       = in_instr[11:7];
    dec.op_a     = rs1_data;
    dec.op_b     = rs2_data;
    case (opcode)
      OPC_OP: begin
        dec.regwrite = 1'b1;
        if (funct7 == F7_BASE)
          dec.alu_control = alu_ctrl(CLS_BASE, funct3);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SRL))
          dec.alu_control = alu_ctrl(CLS_ALT, funct3);
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.regwrite    = 1'b1;
        dec.op_b        = imm_i;
        dec.alu_control = alu_ctrl(CLS_BASE, funct3);
        if (funct3 == F3_SLL || funct3 == F3_SRL) begin
          dec.op_b = 32'(in_instr[24:20]);
          if (funct7 == F7_ALT && funct3 == F3_SRL)
            dec.alu_control = alu_ctrl(CLS_ALT, funct3);
          else if (funct7 != F7_BASE)
            dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.regwrite = 1'b1;
        dec.op_a     = '0;
        dec.op_b     = imm_u;
      end
      OPC_AUIPC: begin
        dec.regwrite = 1'b1;
        dec.op_a     = in_pc;
        dec.op_b     = imm_u;
      end
      OPC_LOAD: begin
        dec.regwrite = 1'b1;
        dec.op_b     = imm_i;
      end
      OPC_STORE: begin
        dec.rd   = '0;
        dec.op_b = imm_s;
      end
      OPC_BRANCH: begin
        // Branches have no destination; their rd field is immediate bits.
        dec.rd          = '0;
        dec.branch_op   = 1'b1;
        dec.alu_control = alu_ctrl(CLS_BR, funct3);
        dec.target      = in_pc + imm_b;
        dec.illegal     = (funct3 == F3_SLT) || (funct3 == F3_SLTU);
      end
      OPC_JAL: begin
        dec.regwrite    = 1'b1;
        dec.jump        = 1'b1;
        dec.alu_control = alu_ctrl(CLS_PASS, F3_ADD);
        dec.op_a        = in_pc + 32'd4;
        dec.op_b        = '0;
        dec.target      = in_pc + imm_j;
      end
      OPC_JALR: begin
        dec.regwrite    = 1'b1;
        dec.jump        = 1'b1;
        dec.alu_control = alu_ctrl(CLS_PASS, F3_ADD);
        dec.op_a        = in_pc + 32'd4;
        dec.op_b        = '0;
        dec.target      = (rs1_data + imm_i) & ~32'd1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_control = '0;
      dec.branch_op   = 1'b0;
      dec.jump        = 1'b0;
      dec.target      = '0;
    end
    if (dec.illegal || dec.rd == 5'd0)
      dec.regwrite = 1'b0;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Output register; flush wins over a simultaneous accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign ALU_Control = out_q.alu_control;
  assign operand_A   = out_q.op_a;
  assign operand_B   = out_q.op_b;
  assign branch_op   = out_q.branch_op;
  assign jump        = out_q.jump;
  assign target      = out_q.target;
  assign rd          = out_q.rd;
  assign regwrite    = out_q.regwrite;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-result queue.
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        clock, reset_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A, operand_B, target;
  logic        branch_op, jump, regwrite, illegal;

  logic [31:0] rf [32];
  exp_t        q[$];
  logic        mv;
  int          errors = 0;
  int          checks = 0;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  decode_stage #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
    .branch_op(branch_op), .jump(jump), .target(target), .rd(rd),
    .regwrite(regwrite), .illegal(illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rdi, op};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] op);
    return {imm, rs1, f3, rdi, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rdi);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rdi, 7'b1101111};
  endfunction

  function automatic exp_t mk(input logic [5:0] alu, input logic [31:0] a, input logic [31:0] b,
      input logic br, input logic jmp, input logic [31:0] tgt, input logic [4:0] rdi,
      input logic rw, input logic ill);
    exp_t e;
    e.alu = alu; e.a = a; e.b = b; e.br = br; e.jmp = jmp;
    e.tgt = tgt; e.rd = rdi; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_out(input exp_t e);
    check("ALU_Control", 32'(ALU_Control), 32'(e.alu));
    check("operand_A", operand_A, e.a);
    check("operand_B", operand_B, e.b);
    check("branch_op", 32'(branch_op), 32'(e.br));
    check("jump", 32'(jump), 32'(e.jmp));
    check("target", target, e.tgt);
    check("rd", 32'(rd), 32'(e.rd));
    check("regwrite", 32'(regwrite), 32'(e.rw));
    check("illegal", 32'(illegal), 32'(e.ill));
  endtask

  // One clock cycle: drive, check the presented output against the queue head, advance.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
      input logic fl, input logic ordy, input exp_t e);
    logic acc;
    in_valid = v; in_instr = instr; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    check("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
    check("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
    check("in_ready", 32'(in_ready), 32'(!mv || ordy));
    check("out_valid", 32'(out_valid), 32'(mv));
    if (mv) begin
      if (q.size() > 0) begin
        cmp_out(q[0]);
        if (fl || ordy) void'(q.pop_front());
      end else begin
        check("queue_underflow", 32'(q.size()), 32'd1);
      end
    end
    acc = v && (!mv || ordy) && !fl;
    if (acc) q.push_back(e);
    @(posedge clock);
    #1;
    if (fl) mv = 1'b0;
    else if (acc) mv = 1'b1;
    else if (ordy) mv = 1'b0;
  endtask

  initial begin
    logic [31:0] i_sub, i_blt, i_addi0, i_jalr, i_jal, i_sw, i_lw, i_srai, i_addi400;
    logic [31:0] i_slli_bad, i_beq_bad, i_unk, i_lui, i_auipc, i_add, i_mul;
    exp_t        e_sub, e_lui, e_auipc, e_mul;

    for (int k = 0; k < 32; k++) rf[k] = 32'h1000 + 32'(k);
    rf[0] = 32'd0; rf[1] = 32'd10; rf[2] = 32'd3; rf[5] = 32'h203;

    clock = 1'b0; reset_n = 1'b0; mv = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;

    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    cmp_out('0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    i_sub      = r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    i_blt      = b_type(13'h1FF8, 5'd2, 5'd1, 3'b100);
    i_addi0    = i_type(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011);
    i_jalr     = i_type(12'd8, 5'd5, 3'b000, 5'd1, 7'b1100111);
    i_jal      = j_type(21'd16, 5'd1);
    i_sw       = s_type(12'd12, 5'd2, 5'd1, 3'b010);
    i_lw       = i_type(12'hFFC, 5'd1, 3'b010, 5'd9, 7'b0000011);
    i_srai     = i_type(12'h403, 5'd1, 3'b101, 5'd10, 7'b0010011);
    i_addi400  = i_type(12'h400, 5'd1, 3'b000, 5'd11, 7'b0010011);
    i_slli_bad = i_type(12'h402, 5'd1, 3'b001, 5'd12, 7'b0010011);
    i_beq_bad  = b_type(13'd8, 5'd2, 5'd1, 3'b010);
    i_unk      = 32'h0000_007F;
    i_lui      = {20'h12345, 5'd4, 7'b0110111};
    i_auipc    = {20'h00001, 5'd6, 7'b0010111};
    i_add      = r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011);
    i_mul      = r_type(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011);

    e_sub   = mk(6'b001000, 32'd10, 32'd3, 1'b0, 1'b0, 32'd0, 5'd3, 1'b1, 1'b0);
    e_lui   = mk(6'b000000, 32'd0, 32'h1234_5000, 1'b0, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0);
    e_auipc = mk(6'b000000, 32'h200, 32'h1000, 1'b0, 1'b0, 32'd0, 5'd6, 1'b1, 1'b0);
    e_mul   = mk(6'b000000, 32'd10, 32'd3, 1'b0, 1'b0, 32'd0, 5'd8, 1'b0, 1'b1);

    // Back-to-back stream with the consumer always ready.
    cycle(1'b1, i_sub, 32'h0, 1'b0, 1'b1, e_sub);
    cycle(1'b1, i_blt, 32'h100, 1'b0, 1'b1,
          mk(6'b010100, 32'd10, 32'd3, 1'b1, 1'b0, 32'hF8, 5'd0, 1'b0, 1'b0));
    cycle(1'b1, i_addi0, 32'h104, 1'b0, 1'b1,
          mk(6'b000000, 32'd0, 32'd1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0));
    cycle(1'b1, i_jalr, 32'h40, 1'b0, 1'b1,
          mk(6'b011000, 32'h44, 32'd0, 1'b0, 1'b1, 32'h20A, 5'd1, 1'b1, 1'b0));
    cycle(1'b1, i_jal, 32'h80, 1'b0, 1'b1,
          mk(6'b011000, 32'h84, 32'd0, 1'b0, 1'b1, 32'h90, 5'd1, 1'b1, 1'b0));
    cycle(1'b1, i_sw, 32'h0, 1'b0, 1'b1,
          mk(6'b000000, 32'd10, 32'd12, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0));
    cycle(1'b1, i_lw, 32'h0, 1'b0, 1'b1,
          mk(6'b000000, 32'd10, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0, 5'd9, 1'b1, 1'b0));
    cycle(1'b1, i_srai, 32'h0, 1'b0, 1'b1,
          mk(6'b001101, 32'd10, 32'd3, 1'b0, 1'b0, 32'd0, 5'd10, 1'b1, 1'b0));
    cycle(1'b1, i_addi400, 32'h0, 1'b0, 1'b1,
          mk(6'b000000, 32'd10, 32'h400, 1'b0, 1'b0, 32'd0, 5'd11, 1'b1, 1'b0));
    cycle(1'b1, i_slli_bad, 32'h0, 1'b0, 1'b1,
          mk(6'b000000, 32'd10, 32'd2, 1'b0, 1'b0, 32'd0, 5'd12, 1'b0, 1'b1));
    cycle(1'b1, i_beq_bad, 32'h0, 1'b0, 1'b1,
          mk(6'b000000, 32'd10, 32'd3, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1));
    cycle(1'b1, i_unk, 32'h0, 1'b0, 1'b1,
          mk(6'b000000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);

    // Backpressure: LUI held for three cycles while AUIPC waits, then both drain.
    cycle(1'b1, i_lui, 32'h0, 1'b0, 1'b1, e_lui);
    for (int k = 0; k < 3; k++) cycle(1'b1, i_auipc, 32'h200, 1'b0, 1'b0, e_auipc);
    cycle(1'b1, i_auipc, 32'h200, 1'b0, 1'b1, e_auipc);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);

    // Flush colliding with an accept, then flush of a held illegal instruction.
    cycle(1'b1, i_add, 32'h0, 1'b1, 1'b1,
          mk(6'b000000, 32'd10, 32'd3, 1'b0, 1'b0, 32'd0, 5'd7, 1'b1, 1'b0));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);
    cycle(1'b1, i_mul, 32'h0, 1'b0, 1'b0, e_mul);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, '0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, '0);

    // Asynchronous reset while an instruction is held.
    cycle(1'b1, i_sub, 32'h0, 1'b0, 1'b0, e_sub);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_alu", 32'(ALU_Control), 32'd0);
    check("async_rst_opA", operand_A, 32'd0);
    q.delete();
    mv = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
